// File: rtl/tron_pkg.sv
// Shared definitions for the Tron score keeper.
// Winner codes, FSM state encodings and BCD digit width.
package tron_pkg;

    localparam int BCD_W = 4;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up-counter, saturating at 99.
// Synchronous clear wins over increment.
import tron_pkg::*;

module bcd_counter_2d (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    // Digit registers: clear, or step ones with carry into tens
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tens <= '0;
            ones <= '0;
        end else if (clear) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones == 4'd9) begin
                if (tens != 4'd9) begin
                    tens <= tens + 4'd1;
                    ones <= '0;
                end
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/tron_score_keeper.sv
// Match score tracker: per-player BCD scores and match-end FSM.
// Optional round counter enabled by TRON_ROUND_COUNT_EN.
import tron_pkg::*;

module tron_score_keeper #(
    parameter int WIN_SCORE = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             round_done,
    input  logic [1:0]       winner,
    input  logic             new_match,
    output logic [BCD_W-1:0] p1_tens,
    output logic [BCD_W-1:0] p1_ones,
    output logic [BCD_W-1:0] p2_tens,
    output logic [BCD_W-1:0] p2_ones,
`ifdef TRON_ROUND_COUNT_EN
    output logic [BCD_W-1:0] rnd_tens,
    output logic [BCD_W-1:0] rnd_ones,
`endif
    output logic             match_over,
    output logic [1:0]       match_winner
);

    // Score one below the target, in BCD, so the
    // win test looks at the pre-increment digits.
    localparam int WM1 = WIN_SCORE - 1;
    localparam logic [BCD_W-1:0] WM1_TENS = BCD_W'(WM1 / 10);
    localparam logic [BCD_W-1:0] WM1_ONES = BCD_W'(WM1 % 10);

    state_t state;
    logic   accept;
    logic   p1_inc;
    logic   p2_inc;
    logic   p1_wins;
    logic   p2_wins;

    assign accept  = (state == ST_PLAY) && round_done && !new_match;
    assign p1_inc  = accept && (winner == WIN_P1);
    assign p2_inc  = accept && (winner == WIN_P2);
    assign p1_wins = p1_inc && (p1_tens == WM1_TENS)
                            && (p1_ones == WM1_ONES);
    assign p2_wins = p2_inc && (p2_tens == WM1_TENS)
                            && (p2_ones == WM1_ONES);

    bcd_counter_2d u_p1 (
        .clock (clock),
        .reset (reset),
        .clear (new_match),
        .inc   (p1_inc),
        .tens  (p1_tens),
        .ones  (p1_ones)
    );

    bcd_counter_2d u_p2 (
        .clock (clock),
        .reset (reset),
        .clear (new_match),
        .inc   (p2_inc),
        .tens  (p2_tens),
        .ones  (p2_ones)
    );

`ifdef TRON_ROUND_COUNT_EN
    bcd_counter_2d u_rnd (
        .clock (clock),
        .reset (reset),
        .clear (new_match),
        .inc   (accept),
        .tens  (rnd_tens),
        .ones  (rnd_ones)
    );
`endif

    // Match FSM; result outputs registered with the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_PLAY;
            match_over   <= 1'b0;
            match_winner <= WIN_NONE;
        end else if (new_match) begin
            state        <= ST_PLAY;
            match_over   <= 1'b0;
            match_winner <= WIN_NONE;
        end else begin
            unique case (state)
                ST_PLAY: begin
                    if (p1_wins) begin
                        state        <= ST_DONE;
                        match_over   <= 1'b1;
                        match_winner <= WIN_P1;
                    end else if (p2_wins) begin
                        state        <= ST_DONE;
                        match_over   <= 1'b1;
                        match_winner <= WIN_P2;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_PLAY;
                end
            endcase
        end
    end

endmodule
